dp_feeder: RTL and testbench

Operand sequencer that drives a `dp_group` array. It accepts a dot-product command giving the reduction length K, then streams K operand beats from an upstream valid/ready source onto the `dp_group` input bus, framing them with first/last flags on `dp_valid`. After the `dp_group` pipeline latency it pulses `res_valid` so a downstream collector can capture the finished `N_UNIT` results.

---
 rtl/dp_feeder.sv | 157 +++++++++++++++
 tb/tb_dp_feeder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_feeder.sv
// dp_feeder: frames K operand beats from a valid/ready source onto a dp_group input bus
// and pulses res_valid once the dp_group pipeline has drained. Option: DP_FEEDER_ZERO_SKIP_EN.
module dp_feeder #(
    parameter int N_UNIT     = 4,
    parameter int N_MUL      = 4,
    parameter int DW_MUL     = 8,
    parameter int DW_UNIT_IN = DW_MUL * N_MUL,
    parameter int KW         = 8,
    parameter int DP_LAT     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [KW-1:0]                cmd_k,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [DW_UNIT_IN-1:0]        op_a,
    input  logic [N_UNIT*DW_UNIT_IN-1:0] op_b,
    input  logic                         dp_stall,
    output logic                         dp_enable,
    output logic [DW_UNIT_IN-1:0]        dp_a,
    output logic [N_UNIT*DW_UNIT_IN-1:0] dp_b,
    output logic [1:0]                   dp_valid,
    output logic                         res_valid,
    output logic                         cmd_err
);

    localparam int DCW = (DP_LAT < 1) ? 1 : $clog2(DP_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [KW-1:0]                  rem_q, rem_d;
    logic                           first_q, first_d;
    logic [DCW-1:0]                 drain_cnt_q, drain_cnt_d;
    logic                           dp_enable_q, dp_enable_d;
    logic [1:0]                     dp_valid_q, dp_valid_d;
    logic [DW_UNIT_IN-1:0]          dp_a_q, dp_a_d;
    logic [N_UNIT*DW_UNIT_IN-1:0]   dp_b_q, dp_b_d;
    logic                           res_valid_q, res_valid_d;
    logic                           cmd_err_q, cmd_err_d;

    logic beat_hs;
    logic beat_last;
    logic beat_skip;

    // Ready is a pure function of state and stall so the source never sees a loop through op_valid.
    assign cmd_ready = (state_q == S_IDLE);
    assign op_ready  = (state_q == S_RUN) && !dp_stall;
    assign beat_hs   = op_valid && op_ready;
    assign beat_last = (rem_q == KW'(1));

`ifdef DP_FEEDER_ZERO_SKIP_EN
    // An all-zero A vector contributes nothing to a middle accumulate, so it is consumed silently.
    assign beat_skip = !first_q && !beat_last && (op_a == '0);
`else
    assign beat_skip = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        first_d     = first_q;
        drain_cnt_d = drain_cnt_q;
        dp_enable_d = 1'b0;
        dp_valid_d  = 2'b00;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        res_valid_d = 1'b0;
        cmd_err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_k == '0) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        rem_d   = cmd_k;
                        first_d = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (beat_hs) begin
                    rem_d   = rem_q - KW'(1);
                    first_d = 1'b0;
                    if (!beat_skip) begin
                        dp_enable_d = 1'b1;
                        dp_valid_d  = {beat_last, first_q};
                        dp_a_d      = op_a;
                        dp_b_d      = op_b;
                    end
                    if (beat_last) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DCW'(DP_LAT);
                        res_valid_d = (DP_LAT == 0);
                    end
                end
            end

            S_DRAIN: begin
                // Stay one extra cycle after the pulse so cmd_ready rises only after res_valid.
                if (drain_cnt_q != '0) begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                    res_valid_d = (drain_cnt_q == DCW'(1));
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            first_q     <= 1'b0;
            drain_cnt_q <= '0;
            dp_enable_q <= 1'b0;
            dp_valid_q  <= 2'b00;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            res_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            drain_cnt_q <= drain_cnt_d;
            dp_enable_q <= dp_enable_d;
            dp_valid_q  <= dp_valid_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            res_valid_q <= res_valid_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign dp_enable = dp_enable_q;
    assign dp_valid  = dp_valid_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign res_valid = res_valid_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_dp_feeder.sv
// Directed bench for dp_feeder: a protocol-level model pushes expected beats to a scoreboard
// at each handshake and pops them when dp_enable is seen.
`timescale 1ns/1ps
module tb_dp_feeder;

    localparam int N_UNIT     = 4;
    localparam int N_MUL      = 4;
    localparam int DW_MUL     = 8;
    localparam int DW_UNIT_IN = DW_MUL * N_MUL;
    localparam int KW         = 8;
    localparam int DP_LAT     = 2;
    localparam int BW         = N_UNIT * DW_UNIT_IN;
`ifdef DP_FEEDER_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [KW-1:0]         cmd_k;
    logic                  op_valid;
    logic                  op_ready;
    logic [DW_UNIT_IN-1:0] op_a;
    logic [BW-1:0]         op_b;
    logic                  dp_stall;
    logic                  dp_enable;
    logic [DW_UNIT_IN-1:0] dp_a;
    logic [BW-1:0]         dp_b;
    logic [1:0]            dp_valid;
    logic                  res_valid;
    logic                  cmd_err;

    typedef struct {
        logic [1:0]            v;
        logic [DW_UNIT_IN-1:0] a;
        logic [BW-1:0]         b;
    } beat_t;

    beat_t sb[$];

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int                    beats_left = 0;
    int                    res_pending = 0;
    bit                    m_first = 1'b0;
    bit                    exp_idle = 1'b1;
    bit                    idle_pending = 1'b0;
    bit                    exp_en_next = 1'b0;
    bit                    exp_err_next = 1'b0;
    bit                    in_reset = 1'b1;
    bit                    last_hs = 1'b0;
    logic [DW_UNIT_IN-1:0] last_a = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200us");
        $fatal(1, "watchdog expired");
    end

    dp_feeder #(
        .N_UNIT(N_UNIT), .N_MUL(N_MUL), .DW_MUL(DW_MUL),
        .DW_UNIT_IN(DW_UNIT_IN), .KW(KW), .DP_LAT(DP_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .dp_stall(dp_stall), .dp_enable(dp_enable), .dp_a(dp_a), .dp_b(dp_b),
        .dp_valid(dp_valid), .res_valid(res_valid), .cmd_err(cmd_err)
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_b();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // One clock: inputs were driven at edge+1; ready is sampled at edge+3, outputs at next edge+1.
    task automatic tick();
        bit    hs;
        bit    last;
        bit    skip;
        bit    exp_ready;
        bit    exp_res;
        beat_t bt;
        #2;
        exp_ready = !in_reset && (beats_left > 0) && !dp_stall;
        check("op_ready", op_ready, exp_ready);
        exp_en_next  = 1'b0;
        exp_err_next = 1'b0;
        hs = 1'b0;
        if (!in_reset && exp_idle && cmd_valid) begin
            if (cmd_k == '0) begin
                exp_err_next = 1'b1;
            end else begin
                beats_left = int'(cmd_k);
                m_first    = 1'b1;
                exp_idle   = 1'b0;
            end
        end else if (exp_ready && op_valid) begin
            hs   = 1'b1;
            last = (beats_left == 1);
            skip = ZS && !m_first && !last && (op_a == '0);
            if (!skip) begin
                bt.v = {last, m_first};
                bt.a = op_a;
                bt.b = op_b;
                sb.push_back(bt);
                exp_en_next = 1'b1;
            end
            m_first = 1'b0;
            beats_left--;
            if (last) res_pending = DP_LAT + 1;
        end
        last_hs = hs;

        @(posedge clk);
        #1;
        check("dp_enable", dp_enable, exp_en_next);
        if (dp_enable === 1'b1) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                bt = sb.pop_front();
                check("dp_valid", dp_valid, bt.v);
                check("dp_a", dp_a, bt.a);
                check("dp_b", dp_b, bt.b);
                last_a = bt.a;
            end
        end else begin
            check("dp_valid_bubble", dp_valid, 2'b00);
            check("dp_a_hold", dp_a, last_a);
        end
        if (idle_pending) begin
            exp_idle     = 1'b1;
            idle_pending = 1'b0;
        end
        exp_res = 1'b0;
        if (res_pending > 0) begin
            res_pending--;
            if (res_pending == 0) begin
                exp_res      = 1'b1;
                idle_pending = 1'b1;
            end
        end
        check("res_valid", res_valid, exp_res);
        check("cmd_err", cmd_err, exp_err_next);
        check("cmd_ready", cmd_ready, exp_idle);
    endtask

    task automatic send_cmd(input int k);
        cmd_valid = 1'b1;
        cmd_k     = KW'(k);
        tick();
        cmd_valid = 1'b0;
        cmd_k     = '0;
    endtask

    task automatic feed_beat(input logic [DW_UNIT_IN-1:0] a);
        int n;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = rand_b();
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_hs && n < 40);
        check("beat_timeout", last_hs, 1);
    endtask

    task automatic wait_idle();
        int n;
        op_valid = 1'b0;
        n = 0;
        while (!exp_idle && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", exp_idle, 1);
        tick();
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic apply_reset_now();
        reset    = 1'b0;
        in_reset = 1'b1;
        op_valid = 1'b0;
        sb.delete();
        beats_left   = 0;
        res_pending  = 0;
        idle_pending = 1'b0;
        m_first      = 1'b0;
        exp_idle     = 1'b1;
        last_a       = '0;
        #1;
        check("rst_dp_enable", dp_enable, 0);
        check("rst_dp_valid", dp_valid, 0);
        check("rst_dp_a", dp_a, 0);
        check("rst_dp_b", dp_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_op_ready", op_ready, 0);
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_k     = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        dp_stall  = 1'b0;

        // Reset state
        apply_reset_now();
        tick();
        tick();
        reset    = 1'b1;
        in_reset = 1'b0;
        tick();

        // K=4 with op_valid held high: 01,00,00,10 back to back, res_valid two cycles later
        send_cmd(4);
        for (int i = 0; i < 4; i++) feed_beat($urandom() | 32'h1);
        wait_idle();

        // K=1: single beat framed 11
        send_cmd(1);
        feed_beat(32'hA5A5_0001);
        wait_idle();

        // K=0: rejected with one cmd_err pulse and no beats
        send_cmd(0);
        tick();
        tick();

        // K=6 with a 3-cycle stall after beat 2 and random source gaps
        send_cmd(6);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                dp_stall = 1'b1;
                op_valid = 1'b1;
                op_a     = 32'hDEAD_0000 | 32'(i + 1);
                repeat (3) tick();
                dp_stall = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) begin
                op_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            feed_beat(32'hC0DE_0000 | 32'(i + 1));
        end
        wait_idle();

        // Reset while beat 3 of K=8 is on the outputs; then K=2 must run cleanly
        send_cmd(8);
        for (int i = 0; i < 3; i++) feed_beat(32'h8000_0000 | 32'(i + 1));
        #2;
        apply_reset_now();
        tick();
        tick();
        reset    = 1'b1;
        in_reset = 1'b0;
        repeat (5) tick();
        send_cmd(2);
        feed_beat(32'h2222_0001);
        feed_beat(32'h2222_0002);
        wait_idle();

        // Zero A on a middle beat: skipped when the option is built in, issued otherwise
        send_cmd(4);
        feed_beat(32'h4444_0001);
        feed_beat(32'h0000_0000);
        feed_beat(32'h4444_0003);
        feed_beat(32'h4444_0004);
        wait_idle();

        // Back-to-back command straight out of the drain
        send_cmd(3);
        for (int i = 0; i < 3; i++) feed_beat($urandom() | 32'h1);
        wait_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
